mcp3_decoder_pipe: RTL and testbench

MCP3_DECODER_PIPE -- requirements
Module: mcp3_decoder_pipe

---
 rtl/mcp3_decoder_pipe.sv | 131 +++++++++++++
 tb/tb_mcp3_decoder_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcp3_decoder_pipe.sv
// Binary-index to one-hot / thermometer decoder with a two-entry output pipeline
// (output register plus skid register) and a saturating out-of-range counter.
module mcp3_decoder_pipe #(
    parameter int DIN_WIDTH  = 4,
    parameter int DOUT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  din_mode,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_err,
    output logic [15:0]           err_count
);

    generate
        if (DOUT_WIDTH < 1 || DOUT_WIDTH > (1 << DIN_WIDTH)) begin : g_bad_width
            $error("mcp3_decoder_pipe: DOUT_WIDTH must lie in 1..2**DIN_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [DOUT_WIDTH-1:0] UNIT = DOUT_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [DOUT_WIDTH-1:0]   out_vec_q, out_vec_d;
    logic                    out_err_q, out_err_d;
    logic [DOUT_WIDTH-1:0]   skid_vec_q, skid_vec_d;
    logic                    skid_err_q, skid_err_d;
    logic [15:0]             err_count_q, err_count_d;

    logic [DOUT_WIDTH-1:0]   onehot;
    logic [DOUT_WIDTH-1:0]   dec_vec;
    logic                    dec_err;
    logic                    accept;
    logic                    emit;

    // Thermometer is (1 << (din+1)) - 1; at din = DOUT_WIDTH-1 the shift wraps
    // to zero and the subtraction yields all ones, which is the wanted result.
    always_comb begin
        onehot  = UNIT << din;
        dec_err = (32'(din) >= 32'(DOUT_WIDTH));
        dec_vec = '0;
        if (!dec_err) begin
            dec_vec = din_mode ? ((onehot << 1) - UNIT) : onehot;
        end
    end

    assign din_ready  = !reset && (state_q != TWO);
    assign dout_valid = (state_q != EMPTY);
    assign dout       = out_vec_q;
    assign dout_err   = out_err_q;
    assign err_count  = err_count_q;

    assign accept = din_valid && din_ready;
    assign emit   = dout_valid && dout_ready;

    always_comb begin
        state_d     = state_q;
        out_vec_d   = out_vec_q;
        out_err_d   = out_err_q;
        skid_vec_d  = skid_vec_q;
        skid_err_d  = skid_err_q;
        err_count_d = err_count_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    out_vec_d = dec_vec;
                    out_err_d = dec_err;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    out_vec_d = dec_vec;
                    out_err_d = dec_err;
                end else if (accept) begin
                    state_d    = TWO;
                    skid_vec_d = dec_vec;
                    skid_err_d = dec_err;
                end else if (emit) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // din_ready is low here, so only the skid-to-output move can occur.
                if (emit) begin
                    state_d   = ONE;
                    out_vec_d = skid_vec_q;
                    out_err_d = skid_err_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (accept && dec_err && (err_count_q != '1)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= EMPTY;
            out_vec_q   <= '0;
            out_err_q   <= 1'b0;
            skid_vec_q  <= '0;
            skid_err_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            out_vec_q   <= out_vec_d;
            out_err_q   <= out_err_d;
            skid_vec_q  <= skid_vec_d;
            skid_err_q  <= skid_err_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_mcp3_decoder_pipe.sv
// Bench for mcp3_decoder_pipe: directed checks on a default-width instance and a
// queue scoreboard with random handshakes on a DOUT_WIDTH=10 instance.
module tb_mcp3_decoder_pipe;

    logic clock;
    logic reset;

    // Default-parameter instance (directed checks)
    logic        a_din_valid, a_din_ready, a_din_mode;
    logic [3:0]  a_din;
    logic        a_dout_valid, a_dout_ready, a_dout_err;
    logic [15:0] a_dout;
    logic [15:0] a_err_count;

    // DOUT_WIDTH=10 instance (scoreboarded)
    logic        b_din_valid, b_din_ready, b_din_mode;
    logic [3:0]  b_din;
    logic        b_dout_valid, b_dout_ready, b_dout_err;
    logic [9:0]  b_dout;
    logic [15:0] b_err_count;

    mcp3_decoder_pipe u_dut_def (
        .clock      (clock),
        .reset      (reset),
        .din_valid  (a_din_valid),
        .din_ready  (a_din_ready),
        .din        (a_din),
        .din_mode   (a_din_mode),
        .dout_valid (a_dout_valid),
        .dout_ready (a_dout_ready),
        .dout       (a_dout),
        .dout_err   (a_dout_err),
        .err_count  (a_err_count)
    );

    mcp3_decoder_pipe #(.DIN_WIDTH(4), .DOUT_WIDTH(10)) u_dut_w10 (
        .clock      (clock),
        .reset      (reset),
        .din_valid  (b_din_valid),
        .din_ready  (b_din_ready),
        .din        (b_din),
        .din_mode   (b_din_mode),
        .dout_valid (b_dout_valid),
        .dout_ready (b_dout_ready),
        .dout       (b_dout),
        .dout_err   (b_dout_err),
        .err_count  (b_err_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode from the rules: out of range -> zero, else 1<<i or (1<<(i+1))-1.
    function automatic int unsigned ref_vec(input int unsigned idx, input bit mode,
                                            input int unsigned w);
        if (idx >= w) return 0;
        if (mode) return (32'd1 << (idx + 1)) - 32'd1;
        return 32'd1 << idx;
    endfunction

    typedef struct {
        int unsigned vec;
        bit          err;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned model_cnt = 0;
    int unsigned acc_n     = 0;

    // Input-side monitor: records expected beats at acceptance.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            sb_q.delete();
            model_cnt = 0;
        end else if (b_din_valid && b_din_ready) begin
            chk("err_count_at_accept", 32'(b_err_count), model_cnt);
            e.vec = ref_vec(int'(b_din), b_din_mode, 10);
            e.err = (int'(b_din) >= 10);
            sb_q.push_back(e);
            if (e.err && model_cnt < 65535) model_cnt++;
            acc_n++;
        end
    end

    // Output-side monitor: pops and compares on every emitted beat; checks stall stability.
    logic        stall_prev = 1'b0;
    logic [9:0]  held_vec;
    logic        held_err;
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_held", 32'(b_dout_valid), 32'd1);
                chk("stall_dout_held", 32'(b_dout), 32'(held_vec));
                chk("stall_err_held", 32'(b_dout_err), 32'(held_err));
            end
            if (b_dout_valid && b_dout_ready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: got dout=0x%0h with nothing expected (t=%0t)",
                             b_dout, $time);
                end else begin
                    e = sb_q.pop_front();
                    if (32'(b_dout) !== e.vec || b_dout_err !== e.err) begin
                        n_err++;
                        $display("FAIL sb_beat: got dout=0x%0h err=%0d, expected dout=0x%0h err=%0d (t=%0t)",
                                 b_dout, b_dout_err, e.vec, e.err, $time);
                    end
                end
            end
            stall_prev = b_dout_valid && !b_dout_ready;
            held_vec   = b_dout;
            held_err   = b_dout_err;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int unsigned target;
        reset        = 1'b1;
        a_din_valid  = 1'b0; a_din = '0; a_din_mode = 1'b0; a_dout_ready = 1'b0;
        b_din_valid  = 1'b0; b_din = '0; b_din_mode = 1'b0; b_dout_ready = 1'b0;
        repeat (3) step();
        @(negedge clock);
        chk("a_din_ready_in_reset", 32'(a_din_ready), 32'd0);
        chk("b_din_ready_in_reset", 32'(b_din_ready), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("a_rst_dout_valid", 32'(a_dout_valid), 32'd0);
        chk("a_rst_dout", 32'(a_dout), 32'd0);
        chk("a_rst_dout_err", 32'(a_dout_err), 32'd0);
        chk("a_rst_err_count", 32'(a_err_count), 32'd0);
        chk("a_rst_din_ready", 32'(a_din_ready), 32'd1);
        chk("b_rst_dout_valid", 32'(b_dout_valid), 32'd0);
        chk("b_rst_err_count", 32'(b_err_count), 32'd0);

        // Back-to-back one-hot then thermometer, one-cycle latency.
        step();
        a_dout_ready = 1'b1;
        a_din = 4'd5; a_din_mode = 1'b0; a_din_valid = 1'b1;
        step();
        a_din_mode = 1'b1;
        @(negedge clock);
        chk("a_onehot5_valid", 32'(a_dout_valid), 32'd1);
        chk("a_onehot5_dout", 32'(a_dout), 32'h0020);
        chk("a_onehot5_err", 32'(a_dout_err), 32'd0);
        step();
        a_din_valid = 1'b0;
        @(negedge clock);
        chk("a_therm5_valid", 32'(a_dout_valid), 32'd1);
        chk("a_therm5_dout", 32'(a_dout), 32'h003F);
        chk("a_therm5_err", 32'(a_dout_err), 32'd0);
        step();
        @(negedge clock);
        chk("a_idle_valid", 32'(a_dout_valid), 32'd0);

        // Backpressure into the skid register.
        step();
        a_dout_ready = 1'b0;
        a_din = 4'd1; a_din_mode = 1'b0; a_din_valid = 1'b1;
        step();
        a_din = 4'd2;
        step();
        a_din_valid = 1'b0;
        @(negedge clock);
        chk("a_two_din_ready", 32'(a_din_ready), 32'd0);
        chk("a_two_dout", 32'(a_dout), 32'h0002);
        step();
        @(negedge clock);
        chk("a_two_hold_dout", 32'(a_dout), 32'h0002);
        chk("a_two_hold_valid", 32'(a_dout_valid), 32'd1);
        step();
        a_dout_ready = 1'b1;
        @(negedge clock);
        chk("a_drain1_dout", 32'(a_dout), 32'h0002);
        step();
        @(negedge clock);
        chk("a_drain2_dout", 32'(a_dout), 32'h0004);
        chk("a_drain2_din_ready", 32'(a_din_ready), 32'd1);
        step();
        @(negedge clock);
        chk("a_drained_valid", 32'(a_dout_valid), 32'd0);

        // Narrow output: out-of-range thermometer, then top in-range one-hot.
        step();
        b_dout_ready = 1'b1;
        b_din = 4'd12; b_din_mode = 1'b1; b_din_valid = 1'b1;
        step();
        b_din = 4'd9; b_din_mode = 1'b0;
        @(negedge clock);
        chk("b_oor_dout", 32'(b_dout), 32'h000);
        chk("b_oor_err", 32'(b_dout_err), 32'd1);
        chk("b_oor_err_count", 32'(b_err_count), 32'd1);
        step();
        b_din_valid = 1'b0;
        @(negedge clock);
        chk("b_top_dout", 32'(b_dout), 32'h200);
        chk("b_top_err", 32'(b_dout_err), 32'd0);

        // Random handshakes on both sides.
        target = acc_n + 4000;
        for (int i = 0; i < 30000 && acc_n < target; i++) begin
            step();
            b_din_valid  = ($urandom_range(0, 3) != 0);
            b_din        = 4'($urandom_range(0, 15));
            b_din_mode   = 1'($urandom_range(0, 1));
            b_dout_ready = ($urandom_range(0, 3) != 0);
        end
        chk("random_beats_reached", 32'(acc_n >= target), 32'd1);
        step();
        b_din_valid  = 1'b0;
        b_dout_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        chk("random_drain_empty", sb_q.size(), 32'd0);

        // Reset while both registers are full.
        step();
        b_dout_ready = 1'b0;
        b_din = 4'd3; b_din_mode = 1'b0; b_din_valid = 1'b1;
        step();
        b_din = 4'd4;
        step();
        b_din_valid = 1'b0;
        @(negedge clock);
        chk("b_two_din_ready", 32'(b_din_ready), 32'd0);
        step();
        reset = 1'b1;
        @(negedge clock);
        chk("b_mid_reset_din_ready", 32'(b_din_ready), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("b_post_reset_valid", 32'(b_dout_valid), 32'd0);
        chk("b_post_reset_err_count", 32'(b_err_count), 32'd0);
        chk("b_post_reset_din_ready", 32'(b_din_ready), 32'd1);
        step();
        b_dout_ready = 1'b1;
        repeat (4) step();

        // Saturation of the error counter.
        b_din = 4'd15; b_din_valid = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            b_din_mode = 1'($urandom_range(0, 1));
            step();
        end
        b_din_valid = 1'b0;
        step();
        @(negedge clock);
        chk("b_err_count_saturated", 32'(b_err_count), 32'h0000FFFF);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        chk("final_drain_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
